// File: rtl/imem_loader.sv
// Byte-stream boot loader: a 16-bit big-endian word count, then N big-endian words
// written to instruction memory, after which the core is released from reset.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_write,
  output logic [31:0] imem_address,
  output logic [31:0] imem_data,
  output logic        core_nrst,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR} state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state_q;
  logic [15:0] n_q;
  logic [1:0]  cnt_q;
  logic [15:0] idx_q;
  logic [23:0] shift_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [15:0] words_q;

  logic        accept;
  logic [15:0] n_d;
  logic [15:0] idx_d;
  logic [31:0] word_d;

  // Gated with nrst so the handshake is closed for the whole reset window.
  assign rx_ready = nrst && (state_q == HDR_HI || state_q == HDR_LO || state_q == DATA);
  assign accept   = rx_valid && rx_ready;
  assign n_d      = {n_q[15:8], rx_data};
  assign idx_d    = idx_q + 16'd1;
  assign word_d   = {shift_q, rx_data};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= HDR_HI;
      n_q     <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      words_q <= '0;
    end else begin
      unique case (state_q)
        HDR_HI: begin
          if (accept) begin
            n_q[15:8] <= rx_data;
            state_q   <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (accept) begin
            n_q <= n_d;
            if (n_d == 16'd0) begin
              state_q <= DONE;
            end else if ({1'b0, n_d} > MAX_W) begin
              state_q <= ERROR;
            end else begin
              cnt_q   <= '0;
              idx_q   <= '0;
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            if (cnt_q == 2'd3) begin
              data_q  <= word_d;
              addr_q  <= BASE_ADDR + {14'd0, idx_q, 2'b00};
              cnt_q   <= '0;
              state_q <= WRITE;
            end else begin
              shift_q <= word_d[23:0];
              cnt_q   <= cnt_q + 2'd1;
            end
          end
        end
        WRITE: begin
          idx_q   <= idx_d;
          words_q <= words_q + 16'd1;
          state_q <= (idx_d == n_q) ? DONE : DATA;
        end
        DONE:    state_q <= DONE;
        ERROR:   state_q <= ERROR;
        default: state_q <= HDR_HI;
      endcase
    end
  end

  assign imem_write   = (state_q == WRITE);
  assign imem_address = addr_q;
  assign imem_data    = data_q;
  assign words_loaded = words_q;
  assign done         = (state_q == DONE);
  assign core_nrst    = (state_q == DONE);
  assign error        = (state_q == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-parameter instance plus a wrapping-base
// instance fed the same byte stream.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;

  logic        rx_ready, imem_write, core_nrst, done, error;
  logic [31:0] imem_address, imem_data;
  logic [15:0] words_loaded;

  logic        rx_ready_w, imem_write_w, core_nrst_w, done_w, error_w;
  logic [31:0] imem_address_w, imem_data_w;
  logic [15:0] words_loaded_w;

  int checks = 0;
  int failures = 0;

  imem_loader dut (
    .clk(clk), .nrst(nrst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_write(imem_write), .imem_address(imem_address), .imem_data(imem_data),
    .core_nrst(core_nrst), .done(done), .error(error), .words_loaded(words_loaded)
  );

  imem_loader #(.BASE_ADDR(32'hFFFF_FFFC), .MAX_WORDS(256)) dut_w (
    .clk(clk), .nrst(nrst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready_w),
    .imem_write(imem_write_w), .imem_address(imem_address_w), .imem_data(imem_data_w),
    .core_nrst(core_nrst_w), .done(done_w), .error(error_w), .words_loaded(words_loaded_w)
  );

  always #5 clk = ~clk;

  // Edge counter and accept tracking, sampled with pre-edge values.
  int cyc = 0;
  int acc = 0;
  int last_acc_cyc = -1;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!nrst) begin
      acc = 0;
    end else if (rx_valid && rx_ready) begin
      acc = acc + 1;
      last_acc_cyc = cyc;
    end
  end

  // Write log, cleared while reset is held.
  logic [31:0] wa[$], wd[$], wa_w[$];
  int wc[$], wacc[$], wlac[$];
  int done_cyc = -1;
  always @(negedge clk) begin
    if (!nrst) begin
      wa.delete(); wd.delete(); wa_w.delete();
      wc.delete(); wacc.delete(); wlac.delete();
      done_cyc = -1;
    end else begin
      if (imem_write) begin
        wa.push_back(imem_address);
        wd.push_back(imem_data);
        wc.push_back(cyc);
        wacc.push_back(acc);
        wlac.push_back(last_acc_cyc);
      end
      if (imem_write_w) wa_w.push_back(imem_address_w);
      if (done && done_cyc < 0) done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'hxx;
    end
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || error) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("end_timeout", 32'(done || error), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_rdy"},   32'(rx_ready), 32'd0);
    chk({tag, "_wr"},    32'(imem_write), 32'd0);
    chk({tag, "_addr"},  imem_address, 32'd0);
    chk({tag, "_data"},  imem_data, 32'd0);
    chk({tag, "_cnrst"}, 32'(core_nrst), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_err"},   32'(error), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  logic [7:0] prog [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
  logic [7:0] one  [6]  = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

  task automatic check_two_words(input string tag);
    chk({tag, "_nwr"},   32'(wa.size()), 32'd2);
    chk({tag, "_a0"},    wa[0], 32'h0000_0000);
    chk({tag, "_d0"},    wd[0], 32'h2008_0005);
    chk({tag, "_a1"},    wa[1], 32'h0000_0004);
    chk({tag, "_d1"},    wd[1], 32'hAC08_0000);
    chk({tag, "_acc0"},  32'(wacc[0]), 32'd6);
    chk({tag, "_acc1"},  32'(wacc[1]), 32'd10);
    chk({tag, "_lat0"},  32'(wc[0]), 32'(wlac[0]));
    chk({tag, "_lat1"},  32'(wc[1]), 32'(wlac[1]));
    chk({tag, "_donec"}, 32'(done_cyc), 32'(wc[1] + 1));
    chk({tag, "_done"},  32'(done), 32'd1);
    chk({tag, "_cnrst"}, 32'(core_nrst), 32'd1);
    chk({tag, "_err"},   32'(error), 32'd0);
    chk({tag, "_rdy"},   32'(rx_ready), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd2);
    chk({tag, "_hold_a"}, imem_address, 32'h0000_0004);
    chk({tag, "_hold_d"}, imem_data, 32'hAC08_0000);
    chk({tag, "_wrlow"}, 32'(imem_write), 32'd0);
  endtask

  initial begin
    // Reset values
    #12;
    check_idle_zero("rst");
    @(negedge clk);
    nrst = 1'b1;

    // Two words back-to-back, also checking the wrapping-base instance
    for (int i = 0; i < 10; i++) send_byte(prog[i], 0);
    wait_end();
    check_two_words("b2b");
    chk("b2b_rate", 32'(wc[1] - wc[0]), 32'd5);
    chk("wrap_nwr", 32'(wa_w.size()), 32'd2);
    chk("wrap_a0", wa_w[0], 32'hFFFF_FFFC);
    chk("wrap_a1", wa_w[1], 32'h0000_0000);
    chk("wrap_done", 32'(done_w), 32'd1);

    // Zero-length program
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    wait_end();
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_cnrst", 32'(core_nrst), 32'd1);
    chk("zero_donec", 32'(done_cyc), 32'(last_acc_cyc));
    chk("zero_nwr", 32'(wa.size()), 32'd0);
    chk("zero_words", 32'(words_loaded), 32'd0);

    // Oversized header (257 > 256)
    do_reset();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    wait_end();
    repeat (3) @(negedge clk);
    chk("big_err", 32'(error), 32'd1);
    chk("big_rdy", 32'(rx_ready), 32'd0);
    chk("big_cnrst", 32'(core_nrst), 32'd0);
    chk("big_done", 32'(done), 32'd0);
    chk("big_nwr", 32'(wa.size()), 32'd0);

    // Same program with rx_valid gaps
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(prog[i], i % 3);
    wait_end();
    check_two_words("gap");

    // Reset in the middle of word 2, then a one-word reload
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(prog[i], 0);
    #2;
    chk("mid_words", 32'(words_loaded), 32'd1);
    chk("mid_data", imem_data, 32'h2008_0005);
    nrst = 1'b0;
    rx_valid = 1'b0;
    #1;
    check_idle_zero("async");
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(one[i], 0);
    wait_end();
    chk("reload_nwr", 32'(wa.size()), 32'd1);
    chk("reload_a0", wa[0], 32'h0000_0000);
    chk("reload_d0", wd[0], 32'hDEAD_BEEF);
    chk("reload_words", 32'(words_loaded), 32'd1);
    chk("reload_done", 32'(done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h00000000, is the byte address at which the first loaded word is written.
REQ-002 Parameter MAX_WORDS, default 256, is the largest word count the header may declare.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port nrst  input  1  is the reset, asynchronous and active-low.
REQ-005 Port rx_data  input  8  is the incoming program byte.
REQ-006 Port rx_valid  input  1  means rx_data holds a valid byte.
REQ-007 Port rx_ready  output  1  means the loader accepts a byte this cycle.
REQ-008 Port imem_write  output  1  is the instruction-memory write strobe.
REQ-009 Port imem_address  output  32  is the instruction-memory byte address.
REQ-010 Port imem_data  output  32  is the instruction word to write.
REQ-011 Port core_nrst  output  1  is the active-low reset released to the processor core.
REQ-012 Port done  output  1  means the load completed.
REQ-013 Port error  output  1  means the header was rejected.
REQ-014 Port words_loaded  output  16  is the count of words written so far.

Function
REQ-015 A byte SHALL be accepted only on a rising edge where rx_valid=1 and rx_ready=1.
REQ-016 The FSM SHALL have the states HDR_HI, HDR_LO, DATA, WRITE, DONE and ERROR.
REQ-017 rx_ready SHALL be 1 in HDR_HI, HDR_LO and DATA, and 0 in WRITE, DONE and ERROR.
REQ-018 Stream format SHALL be a 16-bit word count N (high byte first) followed by 4*N bytes, each word big-endian (first byte goes to [31:24]).
REQ-019 HDR_HI SHALL go to HDR_LO on accept.
REQ-020 On accept in HDR_LO the FSM SHALL go to DONE if N==0, to ERROR if N>MAX_WORDS, else to DATA with the byte counter and word index cleared.
REQ-021 DATA SHALL shift in accepted bytes, and on accepting the 4th byte of a word SHALL go to WRITE on that edge.
REQ-022 WRITE SHALL last exactly one cycle with imem_write=1, imem_address=BASE_ADDR+4*word_index (modulo 2^32) and imem_data equal to the assembled word.
REQ-023 On leaving WRITE, word_index and words_loaded SHALL increment, and the FSM SHALL go to DONE if the incremented index equals N, else back to DATA.
REQ-024 imem_write SHALL be 0 in all states except WRITE; imem_address and imem_data SHALL hold their last values outside WRITE.
REQ-025 A gap in rx_valid SHALL stall the loader without loss of a partial word, and SHALL NOT trigger a timeout.
REQ-026 In DONE: done=1, core_nrst=1, and the FSM holds until reset.
REQ-027 In ERROR: error=1, core_nrst=0, and the FSM holds until reset.
REQ-028 core_nrst SHALL be 0 in every state other than DONE; done, error and core_nrst SHALL be decoded from registered state only.
REQ-029 Minimum throughput SHALL be one word per 5 cycles (4 accepts plus 1 write), with imem_write high in the cycle after the 4th-byte accept edge.

Reset
REQ-030 While nrst=0 the FSM SHALL be forced immediately to HDR_HI.
REQ-031 While nrst=0 the outputs SHALL be rx_ready=0, imem_write=0, imem_address=0, imem_data=0, core_nrst=0, done=0, error=0 and words_loaded=0.
REQ-032 While nrst=0 the counters and any partial word SHALL be cleared.
REQ-033 The first accept after nrst rises SHALL be treated as HDR_HI.
REQ-034 Reset mid-load SHALL NOT erase words already written; the next load SHALL restart at BASE_ADDR.

Verification
REQ-035 Bytes 00 02 20 08 00 05 AC 08 00 00 sent back-to-back -> write addr 0x0 data 0x20080005, then write addr 0x4 data 0xAC080000; done=1, core_nrst=1 the cycle after the 2nd write; words_loaded=2.
REQ-036 Bytes 00 00 -> done=1 and core_nrst=1 the cycle after the HDR_LO accept; no imem_write pulse.
REQ-037 Header 01 01 with MAX_WORDS=256 -> error=1, rx_ready=0, core_nrst stays 0 with no writes.
REQ-038 Random rx_valid gaps within a word -> identical write data and addresses as the back-to-back case; no write before the 4th byte is accepted.
REQ-039 nrst pulsed low after 2 bytes of word 2 -> all outputs 0 asynchronously; a following 1-word load writes at BASE_ADDR with words_loaded=1.
REQ-040 BASE_ADDR=0xFFFFFFFC with N=2 -> writes at 0xFFFFFFFC then 0x00000000.
